// File: rtl/demosaic_acpi_axi4l_regs_if.sv
// demosaic_acpi_axi4l_regs_if: AXI4-Lite bus bundle between the CPU and the demosaic register block.
interface demosaic_acpi_axi4l_regs_if #(
    parameter int AXI4L_ADDR_BITS = 32,
    parameter int AXI4L_DATA_BITS = 32
);
    logic [AXI4L_ADDR_BITS-1:0]   awaddr;
    logic [2:0]                   awprot;
    logic                         awvalid;
    logic                         awready;
    logic [AXI4L_DATA_BITS-1:0]   wdata;
    logic [AXI4L_DATA_BITS/8-1:0] wstrb;
    logic                         wvalid;
    logic                         wready;
    logic [1:0]                   bresp;
    logic                         bvalid;
    logic                         bready;
    logic [AXI4L_ADDR_BITS-1:0]   araddr;
    logic [2:0]                   arprot;
    logic                         arvalid;
    logic                         arready;
    logic [AXI4L_DATA_BITS-1:0]   rdata;
    logic [1:0]                   rresp;
    logic                         rvalid;
    logic                         rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/demosaic_acpi_axi4l_regs.sv
// demosaic_acpi_axi4l_regs: AXI4-Lite registers for the Bayer demosaic core, with settings
// shadowed and applied to the datapath only on a frame-start update request.
module demosaic_acpi_axi4l_regs #(
    parameter int          AXI4L_ADDR_BITS  = 32,
    parameter int          AXI4L_DATA_BITS  = 32,
    parameter logic [31:0] CORE_ID          = 32'h527a_2260,
    parameter logic [31:0] CORE_VERSION     = 32'h0003_0000,
    parameter logic [1:0]  INIT_CTL_CONTROL = 2'b00,
    parameter logic [1:0]  INIT_PARAM_PHASE = 2'b00
) (
    input  logic                             clk,
    input  logic                             reset,
    demosaic_acpi_axi4l_regs_if.slave        s_axi4l,
    input  logic                             in_update_req,
    output logic                             out_enable,
    output logic [1:0]                       out_param_phase
);
    logic        wr_hs, rd_hs, upd, wr_ctl, wr_phase;
    logic [7:0]  widx, ridx;
    logic [1:0]  ctl_q, ctl_d, phase_q, phase_d, cur_phase_q, cur_phase_d;
    logic        cur_en_q, cur_en_d;
    logic [15:0] index_q, index_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic        unused;

    assign wr_hs    = s_axi4l.awvalid & s_axi4l.wvalid & ~bvalid_q;
    assign rd_hs    = s_axi4l.arvalid & ~rvalid_q;
    assign upd      = in_update_req & ctl_q[1];
    assign widx     = s_axi4l.awaddr[9:2];
    assign ridx     = s_axi4l.araddr[9:2];
    assign wr_ctl   = wr_hs & s_axi4l.wstrb[0] & (widx == 8'h04);
    assign wr_phase = wr_hs & s_axi4l.wstrb[0] & (widx == 8'h08);

    assign s_axi4l.awready = wr_hs;
    assign s_axi4l.wready  = wr_hs;
    assign s_axi4l.bresp   = 2'b00;
    assign s_axi4l.bvalid  = bvalid_q;
    assign s_axi4l.arready = ~rvalid_q;
    assign s_axi4l.rresp   = 2'b00;
    assign s_axi4l.rvalid  = rvalid_q;
    assign s_axi4l.rdata   = rdata_q;
    assign out_enable      = cur_en_q;
    assign out_param_phase = cur_phase_q;

    assign unused = ^{s_axi4l.awprot, s_axi4l.arprot,
                      s_axi4l.awaddr[AXI4L_ADDR_BITS-1:10], s_axi4l.awaddr[1:0],
                      s_axi4l.araddr[AXI4L_ADDR_BITS-1:10], s_axi4l.araddr[1:0],
                      s_axi4l.wdata[AXI4L_DATA_BITS-1:2], s_axi4l.wstrb[AXI4L_DATA_BITS/8-1:1]};

    // The update samples pre-write values; a same-cycle bus write then wins the register contents.
    always_comb begin
        rd_val      = ridx == 8'h00 ? CORE_ID :
                      ridx == 8'h01 ? CORE_VERSION :
                      ridx == 8'h04 ? {30'd0, ctl_q} :
                      ridx == 8'h05 ? {31'd0, cur_en_q} :
                      ridx == 8'h07 ? {16'd0, index_q} :
                      ridx == 8'h08 ? {30'd0, phase_q} :
                      ridx == 8'h18 ? {30'd0, cur_phase_q} : 32'd0;
        ctl_d       = wr_ctl ? s_axi4l.wdata[1:0] : upd ? {1'b0, ctl_q[0]} : ctl_q;
        phase_d     = wr_phase ? s_axi4l.wdata[1:0] : phase_q;
        cur_en_d    = upd ? ctl_q[0] : cur_en_q;
        cur_phase_d = upd ? phase_q : cur_phase_q;
        index_d     = upd ? index_q + 16'd1 : index_q;
        bvalid_d    = wr_hs | (bvalid_q & ~s_axi4l.bready);
        rvalid_d    = rd_hs | (rvalid_q & ~s_axi4l.rready);
        rdata_d     = rd_hs ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q       <= INIT_CTL_CONTROL;
            phase_q     <= INIT_PARAM_PHASE;
            cur_en_q    <= INIT_CTL_CONTROL[0];
            cur_phase_q <= INIT_PARAM_PHASE;
            index_q     <= 16'd0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            ctl_q       <= ctl_d;
            phase_q     <= phase_d;
            cur_en_q    <= cur_en_d;
            cur_phase_q <= cur_phase_d;
            index_q     <= index_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end
endmodule

// File: tb/tb_demosaic_acpi_axi4l_regs.sv
// tb_demosaic_acpi_axi4l_regs: randomized bench for the demosaic register block against a
// register-map level model of the shadow-update behaviour.
module tb_demosaic_acpi_axi4l_regs;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_update_req = 1'b0;
    logic out_enable;
    logic [1:0] out_param_phase;
    int checks = 0;
    int passed = 0;

    logic [1:0]  m_ctl, m_phase, m_cur;
    logic        m_en;
    logic [15:0] m_index;

    demosaic_acpi_axi4l_regs_if #(.AXI4L_ADDR_BITS(32), .AXI4L_DATA_BITS(32)) bus ();

    demosaic_acpi_axi4l_regs dut (
        .clk(clk), .reset(reset), .s_axi4l(bus),
        .in_update_req(in_update_req), .out_enable(out_enable), .out_param_phase(out_param_phase)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        case (a[9:2])
            8'h00: return 32'h527a_2260;
            8'h01: return 32'h0003_0000;
            8'h04: return {30'd0, m_ctl};
            8'h05: return {31'd0, m_en};
            8'h07: return {16'd0, m_index};
            8'h08: return {30'd0, m_phase};
            8'h18: return {30'd0, m_cur};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_ctl = 2'b00; m_phase = 2'b00; m_cur = 2'b00; m_en = 1'b0; m_index = 16'd0;
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (s[0] && a[9:2] == 8'h04) m_ctl = d[1:0];
        if (s[0] && a[9:2] == 8'h08) m_phase = d[1:0];
    endtask

    task automatic m_update();
        if (m_ctl[1]) begin
            m_en = m_ctl[0];
            m_cur = m_phase;
            m_ctl[1] = 1'b0;
            m_index = m_index + 16'd1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        #1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 20) $display("FAIL write_timeout addr=%h bvalid=%b required=1", a, bus.bvalid);
        else passed++;
        @(posedge clk); #1;
        m_write(a, d, s);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        #1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 20) $display("FAIL read_timeout addr=%h rvalid=%b required=1", a, bus.rvalid);
        else passed++;
        d = bus.rdata; r = bus.rresp;
        @(posedge clk); #1;
    endtask

    task automatic pulse_update();
        @(negedge clk); in_update_req = 1'b1;
        @(negedge clk); in_update_req = 1'b0;
        m_update();
    endtask

    task automatic check_read(input string name, input logic [31:0] a);
        logic [31:0] d; logic [1:0] r;
        bus_read(a, d, r);
        checks++;
        if (d !== exp_read(a) || r !== 2'b00)
            $display("FAIL %s addr=%h got=%h/%b required=%h/00", name, a, d, r, exp_read(a));
        else passed++;
    endtask

    task automatic check_outputs(input string name);
        checks++;
        if (out_enable !== m_en || out_param_phase !== m_cur)
            $display("FAIL %s outputs got en=%b ph=%0d required en=%b ph=%0d", name, out_enable, out_param_phase, m_en, m_cur);
        else passed++;
    endtask

    task automatic test_reset();
        bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 1; bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 1;
        m_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'd0)
            $display("FAIL reset_bus got b=%b r=%b rdata=%h required 0/0/0", bus.bvalid, bus.rvalid, bus.rdata);
        else passed++;
        reset = 1'b0;
        check_outputs("reset");
        check_read("core_id", 32'h0000_0000);
        check_read("core_version", 32'h0000_0004);
    endtask

    task automatic test_shadow_update();
        bus_write(32'h020, 32'h3, 4'hf);
        bus_write(32'h010, 32'h3, 4'hf);
        checks++;
        if (out_enable !== 1'b0 || out_param_phase !== 2'd0)
            $display("FAIL pre_update_outputs got en=%b ph=%0d required en=0 ph=0", out_enable, out_param_phase);
        else passed++;
        pulse_update();
        check_outputs("shadow_update");
        check_read("ctl_after_update", 32'h010);
        check_read("status", 32'h014);
        check_read("index", 32'h01c);
        check_read("current_phase", 32'h060);
    endtask

    task automatic test_no_update();
        bus_write(32'h020, 32'h2, 4'hf);
        pulse_update();
        check_outputs("no_update");
        check_read("index_no_update", 32'h01c);
        check_read("phase_no_update", 32'h020);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.bready = 1'b0;
        bus.awaddr = 32'h020; bus.wdata = 32'h1; bus.wstrb = 4'hf; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        m_write(32'h020, 32'h1, 4'hf);
        bus.wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0)
                $display("FAIL backpressure_%0d got b=%b aw=%b w=%b required 1/0/0", i, bus.bvalid, bus.awready, bus.wready);
            else passed++;
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1)
            $display("FAIL backpressure_release got b=%b aw=%b required 0/1", bus.bvalid, bus.awready);
        else passed++;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        m_write(32'h020, 32'h0, 4'hf);
        checks++;
        if (bus.bvalid !== 1'b1) $display("FAIL second_write_resp got b=%b required 1", bus.bvalid);
        else passed++;
        @(posedge clk); #1;
        check_read("phase_after_b2b", 32'h020);
    endtask

    task automatic test_strobe_unmapped();
        bus_write(32'h020, 32'h3, 4'h0);
        check_read("phase_wstrb0", 32'h020);
        check_read("unmapped", 32'h0fc);
        bus_write(32'h000, 32'hffff_ffff, 4'hf);
        check_read("ro_core_id", 32'h000);
        bus_write(32'h820, 32'h2, 4'h1);
        check_read("high_addr_alias", 32'h420);
    endtask

    task automatic test_simultaneous();
        bus_write(32'h010, 32'h2, 4'hf);
        @(negedge clk);
        bus.awaddr = 32'h010; bus.wdata = 32'h3; bus.wstrb = 4'hf; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        in_update_req = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; in_update_req = 1'b0;
        m_update();
        m_write(32'h010, 32'h3, 4'hf);
        @(posedge clk); #1;
        checks++;
        if (out_enable !== 1'b0) $display("FAIL simul_enable got=%b required=0", out_enable);
        else passed++;
        check_outputs("simultaneous");
        check_read("simul_ctl", 32'h010);
        check_read("simul_index", 32'h01c);
    endtask

    task automatic test_random();
        logic [7:0] widx [8] = '{8'h04, 8'h08, 8'h04, 8'h08, 8'h00, 8'h05, 8'h18, 8'h3f};
        logic [7:0] ridx [9] = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h07, 8'h08, 8'h18, 8'h02, 8'hff};
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = ($urandom & 32'hffff_fc00) | {22'd0, widx[$urandom_range(0, 7)], 2'b00};
                    bus_write(a, $urandom, 4'($urandom));
                end
                1: begin
                    a = ($urandom & 32'hffff_fc00) | {22'd0, ridx[$urandom_range(0, 8)], 2'b00};
                    check_read("random_read", a);
                end
                default: begin
                    pulse_update();
                    check_outputs("random_update");
                end
            endcase
        end
    endtask

    task automatic test_reset_midtxn();
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 32'h020; bus.wdata = 32'h3; bus.wstrb = 4'hf; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h000; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'd0 || out_enable !== 1'b0 || out_param_phase !== 2'd0)
            $display("FAIL async_reset got b=%b r=%b rdata=%h en=%b ph=%0d required 0/0/0/0/0",
                     bus.bvalid, bus.rvalid, bus.rdata, out_enable, out_param_phase);
        else passed++;
        m_reset();
        @(negedge clk);
        reset = 1'b0; bus.bready = 1'b1; bus.rready = 1'b1;
        check_read("phase_after_reset", 32'h020);
        check_read("index_after_reset", 32'h01c);
    endtask

    initial begin
        test_reset();
        test_shadow_update();
        test_no_update();
        test_back_to_back();
        test_strobe_unmapped();
        test_simultaneous();
        test_random();
        test_reset_midtxn();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/demosaic_acpi_axi4l_regs.md
Name: demosaic_acpi_axi4l_regs

Overview:
- AXI4-Lite slave register block for the ACPI Bayer demosaic core.
- Holds the core ID/version, the enable, and the Bayer phase parameter.
- Transfers new settings to the datapath only at frame boundaries, through a shadow-update handshake.
- Sits between the CPU AXI4-Lite bus and the demosaic pipeline, all on a single clock.

Parameters:
- AXI4L_ADDR_BITS, 32: AXI4-Lite address width.
- AXI4L_DATA_BITS, 32: AXI4-Lite data width. Must be 32.
- CORE_ID, 32'h527a_2260: value returned by the CORE_ID register.
- CORE_VERSION, 32'h0003_0000: value returned by the CORE_VERSION register.
- INIT_CTL_CONTROL, 2'b00: reset value of CTL_CONTROL.
- INIT_PARAM_PHASE, 2'b00: reset value of PARAM_PHASE and of the current phase.

Ports:
- reset  in  1  Asynchronous, active-high reset.
- clk  in  1  Single clock for both the bus and the datapath.
- s_axi4l_awaddr  in  AXI4L_ADDR_BITS  Write address.
- s_axi4l_awprot  in  3  Ignored.
- s_axi4l_awvalid  in  1  Write address valid.
- s_axi4l_awready  out  1  Write address ready.
- s_axi4l_wdata  in  AXI4L_DATA_BITS  Write data.
- s_axi4l_wstrb  in  AXI4L_DATA_BITS/8  Byte-lane strobes.
- s_axi4l_wvalid  in  1  Write data valid.
- s_axi4l_wready  out  1  Write data ready.
- s_axi4l_bresp  out  2  Write response, always 0.
- s_axi4l_bvalid  out  1  Write response valid.
- s_axi4l_bready  in  1  Write response ready.
- s_axi4l_araddr  in  AXI4L_ADDR_BITS  Read address.
- s_axi4l_arprot  in  3  Ignored.
- s_axi4l_arvalid  in  1  Read address valid.
- s_axi4l_arready  out  1  Read address ready.
- s_axi4l_rdata  out  AXI4L_DATA_BITS  Read data.
- s_axi4l_rresp  out  2  Read response, always 0.
- s_axi4l_rvalid  out  1  Read data valid.
- s_axi4l_rready  in  1  Read data ready.
- in_update_req  in  1  One-cycle pulse at frame start from the datapath.
- out_enable  out  1  Current (applied) enable.
- out_param_phase  out  2  Current (applied) Bayer phase.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-high.
- Reset values:
  - bvalid = 0, rvalid = 0, rdata = 0.
  - CTL_CONTROL = INIT_CTL_CONTROL; PARAM_PHASE = INIT_PARAM_PHASE.
  - Current enable = INIT_CTL_CONTROL[0]; current phase = INIT_PARAM_PHASE.
  - CTL_INDEX = 0.
- Write channel:
  - awready = wready = awvalid & wvalid & ~bvalid (combinational). AW and W are accepted in the same cycle only.
  - On the handshake, the register is updated honouring wstrb per byte, and bvalid is set on the next edge.
  - bvalid holds until bready; no new write is accepted while bvalid = 1.
- Read channel:
  - arready = ~rvalid.
  - On the handshake, rdata is registered and rvalid is set on the next edge.
  - rvalid and rdata hold until rready.
- Address decode: word index = addr[9:2]; higher bits are ignored.
- Register map (word index):
  - 0x00 CORE_ID: RO.
  - 0x01 CORE_VERSION: RO.
  - 0x04 CTL_CONTROL: RW [1:0]. Bit0 = enable request; bit1 = update request.
  - 0x05 CTL_STATUS: RO. Bit0 = current enable.
  - 0x07 CTL_INDEX: RO [15:0]. Count of applied updates; wraps 0xFFFF -> 0.
  - 0x08 PARAM_PHASE: RW [1:0].
  - 0x18 CURRENT_PHASE: RO [1:0].
- Unused bits read 0. Unmapped addresses read 0 and ignore writes. Writes to RO registers are ignored. All responses are OKAY.
- Shadow update: on a cycle with in_update_req = 1 and CTL_CONTROL[1] = 1, on the next edge:
  - current enable <= CTL_CONTROL[0];
  - current phase <= PARAM_PHASE;
  - CTL_CONTROL[1] <= 0;
  - CTL_INDEX increments.
- If in_update_req = 1 while CTL_CONTROL[1] = 0, nothing changes.
- Simultaneous bus write and update in the same cycle:
  - The update applies the pre-write register values.
  - The bus write to CTL_CONTROL or PARAM_PHASE then takes priority for the register contents, so a newly written bit1 = 1 stays set.
- out_enable and out_param_phase are driven directly from the current registers, with zero additional latency.
- Reset mid-transaction: all pending responses are dropped and every register returns to its reset value.

Test Plan:
- After reset, read 0x000 / 0x004 -> rdata 0x527a2260 / 0x00030000, rresp 0; out_enable = 0, out_param_phase = 0.
- Write PARAM_PHASE (addr 0x020) = 3 and CTL_CONTROL (addr 0x010) = 3, then pulse in_update_req:
  - next cycle out_param_phase = 3, out_enable = 1;
  - read 0x010 -> 1; read 0x014 -> 1; read 0x01C -> 1; read 0x060 -> 3.
- Write PARAM_PHASE = 2 without setting bit1, then pulse in_update_req -> out_param_phase stays 3 and CTL_INDEX stays 1.
- Hold bready = 0 after a write -> bvalid stays 1 and awready/wready stay 0 for a second write until bready is asserted.
- Write PARAM_PHASE with wstrb = 0 -> read-back is unchanged. Read of unmapped 0x0FC -> 0, rresp 0.
- Write CTL_CONTROL = 3 in the same cycle as an in_update_req pulse while CTL_CONTROL = 2:
  - update applies the old values (enable = 0);
  - afterwards CTL_CONTROL reads 3.
